// File: rtl/axis_slave_fifo_if.sv
// axis_slave_fifo_if: upstream/downstream handshake bundle
// for the first-word-fall-through slave buffer.
interface axis_slave_fifo_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data_out;
  logic              data_out_valid;
  logic              data_out_ready;
  logic [LW-1:0]     level;
  logic [CNT_W-1:0]  xfer_cnt;
  logic              protocol_err;

  modport slave (
    input  data,
    input  valid,
    input  data_out_ready,
    output ready,
    output data_out,
    output data_out_valid,
    output level,
    output xfer_cnt,
    output protocol_err
  );

  modport master (
    output data,
    output valid,
    output data_out_ready,
    input  ready,
    input  data_out,
    input  data_out_valid,
    input  level,
    input  xfer_cnt,
    input  protocol_err
  );
endinterface

// File: rtl/axis_slave_fifo.sv
// axis_slave_fifo: FWFT buffer with registered ready,
// beat counter and sticky upstream protocol checker.
module axis_slave_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic rst_n,
  axis_slave_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0]     wp_q, wp_d;
  logic [AW-1:0]     rp_q, rp_d;
  logic [LW-1:0]     lvl_q, lvl_d;
  logic              rdy_q, rdy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              stall_q, stall_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  logic empty;
  logic wr;
  logic rd;

  assign empty = (lvl_q == '0);
  assign wr    = bus.valid & rdy_q;
  assign rd    = ~empty & bus.data_out_ready;

  // next-state for pointers, level, ready, counter and checker
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    lvl_d   = lvl_q;
    cnt_d   = cnt_q;
    if (wr) begin
      wp_d  = wp_q + AW'(1);
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (rd) begin
      rp_d  = rp_q + AW'(1);
    end
    unique case ({wr, rd})
      2'b10:   lvl_d = lvl_q + LW'(1);
      2'b01:   lvl_d = lvl_q - LW'(1);
      default: lvl_d = lvl_q;
    endcase
    rdy_d   = (lvl_d < FULL);
    stall_d = bus.valid & ~rdy_q;
    hold_d  = bus.data;
    err_d   = err_q |
              (stall_q &
               (~bus.valid | (bus.data != hold_q)));
  end

  // control state with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      lvl_q   <= '0;
      rdy_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      stall_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      lvl_q   <= lvl_d;
      rdy_q   <= rdy_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      stall_q <= stall_d;
      hold_q  <= hold_d;
    end
  end

  // storage array; contents are don't-care across reset
  always_ff @(posedge clk) begin
    if (rst_n && wr) begin
      mem_q[wp_q] <= bus.data;
    end
  end

  assign bus.ready          = rdy_q;
  assign bus.data_out_valid = ~empty;
  assign bus.data_out       = empty ? '0 : mem_q[rp_q];
  assign bus.level          = lvl_q;
  assign bus.xfer_cnt       = cnt_q;
  assign bus.protocol_err   = err_q;
endmodule

// File: tb/tb_axis_slave_fifo.sv
// tb_axis_slave_fifo: directed + random stimulus
// against a queue-based reference model.
module tb_axis_slave_fifo;
  localparam int DW = 32;
  localparam int DP = 4;
  localparam int CW = 4;

  logic clk;
  logic rst_n;
  int   n_run;
  int   n_fail;

  axis_slave_fifo_if #(
    .DATA_W(DW), .DEPTH(DP), .CNT_W(CW)
  ) bus ();

  axis_slave_fifo #(
    .DATA_W(DW), .DEPTH(DP), .CNT_W(CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] q[$];
  logic          m_rdy;
  logic [CW-1:0] m_cnt;
  logic          m_err;
  logic          p_stall;
  logic [DW-1:0] p_d;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h",
               tag, got, exp);
    end
  endtask

  task automatic chk_all();
    logic [DW-1:0] hd;
    hd = (q.size() != 0) ? q[0] : '0;
    chk("ready", 64'(bus.ready), 64'(m_rdy));
    chk("ovalid", 64'(bus.data_out_valid),
        64'(q.size() != 0));
    chk("dout", 64'(bus.data_out), 64'(hd));
    chk("level", 64'(bus.level), 64'(q.size()));
    chk("cnt", 64'(bus.xfer_cnt), 64'(m_cnt));
    chk("perr", 64'(bus.protocol_err), 64'(m_err));
  endtask

  task automatic cyc(input logic v,
                     input logic [DW-1:0] d,
                     input logic dor,
                     input logic rn = 1'b1);
    logic wr;
    logic rd;
    bus.valid          = v;
    bus.data           = d;
    bus.data_out_ready = dor;
    rst_n              = rn;
    wr = v && m_rdy;
    rd = (q.size() != 0) && dor;
    @(posedge clk);
    if (!rn) begin
      q.delete();
      m_rdy   = 1'b0;
      m_cnt   = '0;
      m_err   = 1'b0;
      p_stall = 1'b0;
      p_d     = '0;
    end else begin
      if (p_stall && (!v || d != p_d)) m_err = 1'b1;
      p_stall = v && !m_rdy;
      p_d     = d;
      if (rd) void'(q.pop_front());
      if (wr) begin
        q.push_back(d);
        m_cnt = m_cnt + 1'b1;
      end
      m_rdy = (q.size() < DP);
    end
    #1;
    chk_all();
  endtask

  task automatic do_reset();
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic          v;
    logic [DW-1:0] d;
    n_run   = 0;
    n_fail  = 0;
    q.delete();
    m_rdy   = 1'b0;
    m_cnt   = '0;
    m_err   = 1'b0;
    p_stall = 1'b0;
    p_d     = '0;

    // reset state
    do_reset();
    chk("rst_ready", 64'(bus.ready), 64'(0));
    chk("rst_dout", 64'(bus.data_out), 64'(0));
    cyc(1'b0, '0, 1'b0);
    chk("rel_ready", 64'(bus.ready), 64'(1));

    // single beat
    cyc(1'b1, 32'hA5A5_0001, 1'b1);
    chk("sb_valid", 64'(bus.data_out_valid), 64'(1));
    chk("sb_data", 64'(bus.data_out),
        64'h0000_0000_A5A5_0001);
    cyc(1'b0, '0, 1'b1);
    chk("sb_level", 64'(bus.level), 64'(0));
    chk("sb_cnt", 64'(bus.xfer_cnt), 64'(1));

    // fill / full
    do_reset();
    cyc(1'b0, '0, 1'b0);
    for (int i = 1; i <= 4; i++)
      cyc(1'b1, DW'(i), 1'b0);
    cyc(1'b1, 32'h5, 1'b0);
    chk("full_level", 64'(bus.level), 64'(4));
    chk("full_ready", 64'(bus.ready), 64'(0));
    chk("full_head", 64'(bus.data_out), 64'(1));
    cyc(1'b1, 32'h5, 1'b1);
    chk("full_rdy1", 64'(bus.ready), 64'(1));
    chk("full_lvl3", 64'(bus.level), 64'(3));
    cyc(1'b1, 32'h5, 1'b0);
    chk("full_acc5", 64'(bus.level), 64'(4));
    for (int i = 2; i <= 5; i++) begin
      chk("drain", 64'(bus.data_out), 64'(i));
      cyc(1'b0, '0, 1'b1);
    end
    chk("drain_lvl", 64'(bus.level), 64'(0));

    // streaming 20 beats
    do_reset();
    cyc(1'b0, '0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, DW'(32'h100 + i), 1'b1);
      chk("str_level", 64'(bus.level), 64'(1));
      chk("str_data", 64'(bus.data_out),
          64'(32'h100 + i));
    end
    chk("str_cnt", 64'(bus.xfer_cnt), 64'(20 % 16));
    cyc(1'b0, '0, 1'b1);

    // counter wrap: 17 beats
    do_reset();
    cyc(1'b0, '0, 1'b0);
    for (int i = 0; i < 17; i++)
      cyc(1'b1, $urandom, 1'b1);
    cyc(1'b0, '0, 1'b1);
    chk("wrap_cnt", 64'(bus.xfer_cnt), 64'(1));

    // mid-operation reset
    do_reset();
    cyc(1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, DW'(32'hDEAD_0000 + i), 1'b0);
    chk("mr_level3", 64'(bus.level), 64'(3));
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("mr_level", 64'(bus.level), 64'(0));
    chk("mr_ovalid", 64'(bus.data_out_valid), 64'(0));
    chk("mr_ready0", 64'(bus.ready), 64'(0));
    cyc(1'b0, '0, 1'b0);
    chk("mr_ready1", 64'(bus.ready), 64'(1));
    cyc(1'b1, 32'h0000_BEEF, 1'b0);
    chk("mr_first", 64'(bus.data_out),
        64'h0000_0000_0000_BEEF);

    // randomized, protocol-compliant traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (p_stall) begin
        v = 1'b1;
        d = p_d;
      end else begin
        v = 1'($urandom_range(0, 1));
        d = $urandom;
      end
      cyc(v, d, 1'($urandom_range(0, 9) < 4));
    end
    chk("rnd_noerr", 64'(bus.protocol_err), 64'(0));

    // protocol error: data change while stalled
    do_reset();
    cyc(1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc(1'b1, DW'(i), 1'b0);
    cyc(1'b1, 32'h10, 1'b0);
    chk("pe_before", 64'(bus.protocol_err), 64'(0));
    cyc(1'b1, 32'h11, 1'b0);
    chk("pe_set", 64'(bus.protocol_err), 64'(1));
    for (int i = 0; i < 6; i++)
      cyc(1'b0, '0, 1'b1);
    chk("pe_drain", 64'(bus.level), 64'(0));
    chk("pe_sticky", 64'(bus.protocol_err), 64'(1));

    // protocol error: valid dropped while stalled
    do_reset();
    cyc(1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc(1'b1, DW'(i), 1'b0);
    cyc(1'b1, 32'h20, 1'b0);
    cyc(1'b0, 32'h20, 1'b0);
    chk("pe_drop", 64'(bus.protocol_err), 64'(1));
    do_reset();
    chk("pe_clear", 64'(bus.protocol_err), 64'(0));

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end
endmodule
